spi_ram_responder: RTL



---
 rtl/spi_ram_responder.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_ram_responder.sv
// SPI mode-0 slave emulating a 23LC-style serial SRAM (READ/WRITE/RDMR) backed by an
// internal byte array, with a host preload port for loading images before use.
`timescale 1ns/1ps
module spi_ram_responder #(
  parameter int         ADDR_BITS    = 13,
  parameter logic [7:0] MODE_REG_VAL = 8'h40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spi_cs_n,
  input  logic                 spi_sclk,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 spi_miso_oe,
  input  logic                 load_we,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [7:0]           load_data,
  output logic                 busy
);

  localparam int MEM_BYTES = 2**ADDR_BITS;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_READ, ST_WRITE, ST_RDMR, ST_IGNORE
  } state_t;

  logic [2:0]           cs_sync_r;
  logic [2:0]           sclk_sync_r;
  logic [1:0]           mosi_sync_r;
  state_t               state_r;
  logic [4:0]           bit_cnt_r;
  logic [7:0]           shift_in_r;
  logic [7:0]           shift_out_r;
  logic [ADDR_BITS-1:0] addr_r;
  logic                 cmd_read_r;
  logic [1:0]           reload_r;
  logic [7:0]           rd_data_r;
  logic                 miso_r;
  logic                 oe_r;
  logic                 busy_r;
  logic [7:0]           mem [0:MEM_BYTES-1];

  logic                 cs_n_s;
  logic                 cs_fall_s;
  logic                 rise_s;
  logic                 fall_s;
  logic                 mosi_s;
  logic [7:0]           byte_in_s;
  logic                 spi_we_s;
  logic [ADDR_BITS-1:0] addr_inc_s;

  assign cs_n_s     = cs_sync_r[1];
  assign cs_fall_s  = cs_sync_r[2] & ~cs_sync_r[1];
  assign rise_s     = sclk_sync_r[1] & ~sclk_sync_r[2];
  assign fall_s     = ~sclk_sync_r[1] & sclk_sync_r[2];
  assign mosi_s     = mosi_sync_r[1];
  assign byte_in_s  = {shift_in_r[6:0], mosi_s};
  assign addr_inc_s = addr_r + {{(ADDR_BITS-1){1'b0}}, 1'b1};
  // An SPI byte commits on the 8th rise pulse of a WRITE; it owns the single write port.
  assign spi_we_s   = ~rst & ~cs_n_s & (state_r == ST_WRITE) & rise_s & (bit_cnt_r == 5'd7);

  assign spi_miso    = miso_r;
  assign spi_miso_oe = oe_r;
  assign busy        = busy_r;

  // Pin synchronizers; the extra stage on cs_n and sclk provides edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync_r   <= 3'b000;
      sclk_sync_r <= 3'b000;
      mosi_sync_r <= 2'b00;
    end else begin
      cs_sync_r   <= {cs_sync_r[1:0], spi_cs_n};
      sclk_sync_r <= {sclk_sync_r[1:0], spi_sclk};
      mosi_sync_r <= {mosi_sync_r[0], spi_mosi};
    end
  end

  // Backing store: one write port (SPI commit beats preload) and a registered read port.
  always_ff @(posedge clk) begin
    if (spi_we_s) begin
      mem[addr_r] <= byte_in_s;
    end else if (load_we) begin
      mem[load_addr] <= load_data;
    end
    rd_data_r <= mem[addr_r];
  end

  // Protocol FSM with registered MISO, output enable and busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      bit_cnt_r   <= 5'd0;
      shift_in_r  <= 8'h00;
      shift_out_r <= 8'h00;
      addr_r      <= {ADDR_BITS{1'b0}};
      cmd_read_r  <= 1'b0;
      reload_r    <= 2'b00;
      miso_r      <= 1'b0;
      oe_r        <= 1'b0;
      busy_r      <= 1'b0;
    end else if (cs_n_s) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 5'd0;
      reload_r  <= 2'b00;
      miso_r    <= 1'b0;
      oe_r      <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      // reload_r[1] marks the cycle where rd_data_r holds mem[addr_r] for the new byte
      reload_r <= {reload_r[0], 1'b0};
      case (state_r)
        ST_IDLE: begin
          if (cs_fall_s) begin
            state_r   <= ST_CMD;
            bit_cnt_r <= 5'd0;
            busy_r    <= 1'b1;
          end
        end
        ST_CMD: begin
          if (rise_s) begin
            shift_in_r <= byte_in_s;
            if (bit_cnt_r == 5'd7) begin
              bit_cnt_r <= 5'd0;
              case (byte_in_s)
                8'h03: begin
                  state_r    <= ST_ADDR;
                  cmd_read_r <= 1'b1;
                end
                8'h02: begin
                  state_r    <= ST_ADDR;
                  cmd_read_r <= 1'b0;
                end
                8'h05: begin
                  state_r     <= ST_RDMR;
                  shift_out_r <= MODE_REG_VAL;
                end
                default: state_r <= ST_IGNORE;
              endcase
            end else begin
              bit_cnt_r <= bit_cnt_r + 5'd1;
            end
          end
        end
        ST_ADDR: begin
          if (rise_s) begin
            addr_r <= {addr_r[ADDR_BITS-2:0], mosi_s};
            if (bit_cnt_r == 5'd23) begin
              bit_cnt_r <= 5'd0;
              if (cmd_read_r) begin
                state_r  <= ST_READ;
                reload_r <= 2'b01;
              end else begin
                state_r <= ST_WRITE;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + 5'd1;
            end
          end
        end
        ST_READ, ST_RDMR: begin
          if (fall_s) begin
            miso_r      <= shift_out_r[7];
            oe_r        <= 1'b1;
            shift_out_r <= {shift_out_r[6:0], 1'b0};
            if (bit_cnt_r == 5'd7) begin
              bit_cnt_r <= 5'd0;
              if (state_r == ST_READ) begin
                addr_r   <= addr_inc_s;
                reload_r <= 2'b01;
              end else begin
                shift_out_r <= MODE_REG_VAL;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + 5'd1;
            end
          end else if (reload_r[1]) begin
            shift_out_r <= rd_data_r;
          end
        end
        ST_WRITE: begin
          if (rise_s) begin
            shift_in_r <= byte_in_s;
            if (bit_cnt_r == 5'd7) begin
              bit_cnt_r <= 5'd0;
              addr_r    <= addr_inc_s;
            end else begin
              bit_cnt_r <= bit_cnt_r + 5'd1;
            end
          end
        end
        ST_IGNORE: state_r <= ST_IGNORE;
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
